// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg: shared FSM encodings, Gray phase constants, direction codes and phase helper.
package quad_decoder_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Position of a Gray phase along the forward sequence 00->01->11->10.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        return (ab == PH_00) ? 2'd0 :
               (ab == PH_01) ? 2'd1 :
               (ab == PH_11) ? 2'd2 :
               (ab == PH_10) ? 2'd3 : 2'd0;
    endfunction

endpackage

// File: rtl/quad_decoder_up_down_counter.sv
// quad_decoder_up_down_counter: wrapping up/down counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (overrides inc/dec)
//   inc, dec   : step up / down by one (mutually exclusive)
//   q          : current count
module quad_decoder_up_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d, q_q;

    always_comb
        q_d = clr ? '0 : inc ? q_q + W'(1) : dec ? q_q - W'(1) : q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;

    assign q = q_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder with wrapping position count and illegal-transition flag.
//   clk, rst_n : clock, async active-low reset
//   a, b       : filtered phase inputs
//   z          : index pulse (only with QUAD_INDEX_EN)
//   clear      : sync zero of count and err
//   count      : signed wrapping position
//   dir        : direction of last counted step (1 = up)
//   step       : one-cycle pulse per counted transition
//   err        : sticky double-bit-change flag
//   idx        : one-cycle pulse per index zeroing (only with QUAD_INDEX_EN)
// Optional feature macro: QUAD_INDEX_EN.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int RES     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic               b,
`ifdef QUAD_INDEX_EN
    input  logic               z,
    output logic               idx,
`endif
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               dir,
    output logic               step,
    output logic               err
);

    if (!(RES == 1 || RES == 2 || RES == 4)) begin : g_res_chk
        $error("quad_decoder: RES must be 1, 2 or 4");
    end

    // Phases whose index has these bits set are skipped as count points.
    localparam logic [1:0] RES_M = (RES == 4) ? 2'd0 : (RES == 2) ? 2'd1 : 2'd3;

    // Returns {up, down}: forward steps count when landing on a count point,
    // reverse steps count when leaving one, so both directions use the same points.
    function automatic logic [1:0] decode(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] p, c, d;
        p = phase_idx(prev);
        c = phase_idx(cur);
        d = c - p;
        return {d == 2'd1 && (c & RES_M) == 2'd0, d == 2'd3 && (p & RES_M) == 2'd0};
    endfunction

    state_t     state_q, state_d;
    logic [1:0] ab_q, ab_d;
    logic       step_q, step_d, dir_q, dir_d, err_q, err_d;
    logic       tracking, bad, zero_idx, inc, dec;
    logic [1:0] ud;

`ifdef QUAD_INDEX_EN
    logic idx_q, idx_d;
`endif

    always_comb begin
        ab_d     = {a, b};
        state_d  = ST_TRACK;
        tracking = state_q == ST_TRACK;
        ud       = tracking ? decode(ab_q, ab_d) : 2'b00;
        bad      = tracking && (ab_q ^ ab_d) == 2'b11;
`ifdef QUAD_INDEX_EN
        zero_idx = tracking && z && ab_d == PH_00;
        idx_d    = zero_idx && !clear;
`else
        zero_idx = 1'b0;
`endif
        inc      = ud[1] && !clear && !zero_idx;
        dec      = ud[0] && !clear && !zero_idx;
        step_d   = inc || dec;
        dir_d    = inc ? DIR_UP : dec ? DIR_DN : dir_q;
        err_d    = !clear && (err_q || bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ab_q    <= PH_00;
            step_q  <= 1'b0;
            dir_q   <= DIR_DN;
            err_q   <= 1'b0;
`ifdef QUAD_INDEX_EN
            idx_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
`ifdef QUAD_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    quad_decoder_up_down_counter #(.W(COUNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear || zero_idx),
        .inc   (inc),
        .dec   (dec),
        .q     (count)
    );

    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;
`ifdef QUAD_INDEX_EN
    assign idx  = idx_q;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: four decoder variants on shared inputs, checked against a transition-table model.
module tb_quad_decoder;

    logic clk = 1'b0, rst_n = 1'b0, a = 1'b0, b = 1'b1, clear = 1'b0;
    logic zv = 1'b0;
    always #5 clk = ~clk;

    localparam int RESV[4]  = '{4, 2, 1, 4};
    localparam int MASKV[4] = '{65535, 65535, 65535, 15};
    localparam logic [1:0] SEQ[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic [15:0] cnt0, cnt1, cnt2;
    logic [3:0]  cntw;
    logic [3:0]  dir_o, step_o, err_o, idx_o;
    logic [15:0] cnt_o[4];
    assign cnt_o[0] = cnt0;
    assign cnt_o[1] = cnt1;
    assign cnt_o[2] = cnt2;
    assign cnt_o[3] = {12'd0, cntw};

`ifdef QUAD_INDEX_EN
    logic z;
    assign z = zv;
`define ZPORTS(n) .z(z), .idx(idx_o[n]),
`else
    assign idx_o = 4'd0;
`define ZPORTS(n)
`endif

    quad_decoder #(.COUNT_W(16), .RES(4)) u0 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), `ZPORTS(0)
        .clear(clear), .count(cnt0), .dir(dir_o[0]), .step(step_o[0]), .err(err_o[0]));
    quad_decoder #(.COUNT_W(16), .RES(2)) u1 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), `ZPORTS(1)
        .clear(clear), .count(cnt1), .dir(dir_o[1]), .step(step_o[1]), .err(err_o[1]));
    quad_decoder #(.COUNT_W(16), .RES(1)) u2 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), `ZPORTS(2)
        .clear(clear), .count(cnt2), .dir(dir_o[2]), .step(step_o[2]), .err(err_o[2]));
    quad_decoder #(.COUNT_W(4), .RES(4)) u3 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), `ZPORTS(3)
        .clear(clear), .count(cntw), .dir(dir_o[3]), .step(step_o[3]), .err(err_o[3]));

    int total = 0, bad = 0, steps_seen = 0;

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Counting rules written out as the explicit transition lists for each resolution.
    function automatic int delta(input int res, input logic [1:0] p, input logic [1:0] c);
        bit f, r;
        f = (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b11) ||
            (p == 2'b11 && c == 2'b10) || (p == 2'b10 && c == 2'b00);
        r = (c == 2'b00 && p == 2'b01) || (c == 2'b01 && p == 2'b11) ||
            (c == 2'b11 && p == 2'b10) || (c == 2'b10 && p == 2'b00);
        if (res == 4) return f ? 1 : r ? -1 : 0;
        if (res == 2) return (f && (c == 2'b11 || c == 2'b00)) ? 1 : (r && (p == 2'b11 || p == 2'b00)) ? -1 : 0;
        return (f && c == 2'b00) ? 1 : (r && p == 2'b00) ? -1 : 0;
    endfunction

    function automatic bit zhit(input bit trk, input logic zz, input logic [1:0] c);
`ifdef QUAD_INDEX_EN
        return trk && zz && c == 2'b00;
`else
        return 1'b0 && trk && zz && c == 2'b00;
`endif
    endfunction

    int         m_cnt[4];
    logic       m_dir[4], m_step[4], m_err[4], m_idx[4];
    logic       m_track;
    logic [1:0] m_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_track <= 1'b0;
            m_prev  <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] <= 0; m_dir[k] <= 1'b0; m_step[k] <= 1'b0; m_err[k] <= 1'b0; m_idx[k] <= 1'b0;
            end
        end else begin
            m_track <= 1'b1;
            m_prev  <= {a, b};
            for (int k = 0; k < 4; k++) begin
                if (clear) begin
                    m_cnt[k] <= 0; m_err[k] <= 1'b0; m_step[k] <= 1'b0; m_idx[k] <= 1'b0;
                end else if (zhit(m_track, zv, {a, b})) begin
                    m_cnt[k] <= 0; m_step[k] <= 1'b0; m_idx[k] <= 1'b1;
                    m_err[k] <= m_err[k] | (m_track && (m_prev ^ {a, b}) == 2'b11);
                end else begin
                    m_idx[k]  <= 1'b0;
                    m_err[k]  <= m_err[k] | (m_track && (m_prev ^ {a, b}) == 2'b11);
                    m_step[k] <= m_track && delta(RESV[k], m_prev, {a, b}) != 0;
                    if (m_track && delta(RESV[k], m_prev, {a, b}) != 0) begin
                        m_cnt[k] <= (m_cnt[k] + delta(RESV[k], m_prev, {a, b})) & MASKV[k];
                        m_dir[k] <= delta(RESV[k], m_prev, {a, b}) > 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                chk("count", k, int'(cnt_o[k]), m_cnt[k]);
                chk("dir", k, int'(dir_o[k]), int'(m_dir[k]));
                chk("step", k, int'(step_o[k]), int'(m_step[k]));
                chk("err", k, int'(err_o[k]), int'(m_err[k]));
                chk("idx", k, int'(idx_o[k]), int'(m_idx[k]));
            end
            steps_seen <= steps_seen + int'(step_o[0]);
        end
    end

    function automatic logic [1:0] nxt(input logic [1:0] x, input bit up);
        int i;
        i = 0;
        for (int j = 0; j < 4; j++) if (SEQ[j] == x) i = j;
        return SEQ[(i + (up ? 1 : 3)) % 4];
    endfunction

    task automatic mv(input logic [1:0] v);
        @(negedge clk);
        {a, b} = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic walk(input int n, input bit up);
        for (int i = 0; i < n; i++) mv(nxt({a, b}, up));
    endtask

    task automatic lit4(input string nm, input int c0, input int c1, input int c2, input int c3);
        chk({nm, "_r4"}, 0, int'(cnt_o[0]), c0);
        chk({nm, "_r2"}, 1, int'(cnt_o[1]), c1);
        chk({nm, "_r1"}, 2, int'(cnt_o[2]), c2);
        chk({nm, "_w4"}, 3, int'(cnt_o[3]), c3);
    endtask

    int s0;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        lit4("rest", 0, 0, 0, 0);
        chk("rest_steps", 0, steps_seen, 0);
        chk("rest_err", 0, int'(err_o[0]), 0);

        s0 = steps_seen;
        walk(16, 1'b1);
        lit4("fwd16", 16, 8, 4, 0);
        chk("fwd16_dir", 0, int'(dir_o[0]), 1);
        chk("fwd16_steps", 0, steps_seen - s0, 16);
        chk("fwd16_err", 0, int'(err_o[0]), 0);
        walk(16, 1'b0);
        lit4("rev16", 0, 0, 0, 0);
        chk("rev16_dir", 0, int'(dir_o[0]), 0);

        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        mv(2'b00);
        lit4("wrap_dn", 16'hFFFF, 0, 0, 4'hF);
        walk(16, 1'b1);
        lit4("wrap_up", 16'h000F, 8, 4, 4'hF);
        mv(2'b10);
        lit4("rev1", 16'h000E, 7, 3, 4'hE);

        mv(2'b01);
        chk("dbl_err", 0, int'(err_o[0]), 1);
        chk("dbl_step", 0, int'(step_o[0]), 0);
        lit4("dbl", 16'h000E, 7, 3, 4'hE);
        mv(2'b11);
        lit4("resume", 16'h000F, 8, 3, 4'hF);
        chk("resume_err", 0, int'(err_o[0]), 1);
        @(negedge clk);
        {a, b} = 2'b10;
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        lit4("clr_mv", 0, 0, 0, 0);
        chk("clr_err", 0, int'(err_o[0]), 0);
        chk("clr_step", 0, int'(step_o[0]), 0);

        walk(37, 1'b1);
        lit4("to37", 37, 19, 10, 5);
`ifdef QUAD_INDEX_EN
        @(negedge clk) zv = 1'b1;
        @(negedge clk) zv = 1'b0;
        chk("z_cnt", 0, int'(cnt_o[0]), 0);
        chk("z_idx", 0, int'(idx_o[0]), 1);
        @(negedge clk);
        chk("z_idx_end", 0, int'(idx_o[0]), 0);
        mv(2'b01);
        @(negedge clk) zv = 1'b1;
        repeat (2) @(negedge clk);
        chk("z01_cnt", 0, int'(cnt_o[0]), 1);
        chk("z01_idx", 0, int'(idx_o[0]), 0);
        @(negedge clk);
        {a, b} = 2'b00;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        zv = 1'b0;
        chk("zclr_cnt", 0, int'(cnt_o[0]), 0);
        chk("zclr_idx", 0, int'(idx_o[0]), 0);
`endif

        for (int i = 0; i < 500; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 50)      {a, b} = nxt({a, b}, 1'b1);
            else if (r < 80) {a, b} = nxt({a, b}, 1'b0);
            else if (r < 86) {a, b} = ~{a, b};
            clear = $urandom_range(0, 29) == 0;
`ifdef QUAD_INDEX_EN
            zv = $urandom_range(0, 3) == 0;
`endif
            if (i == 250) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        clear = 1'b0;
        zv = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
